// File: rtl/freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM state encodings.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } fm_state_e;

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a one-cycle
// rising-edge pulse; reusable for buttons and other async inputs.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous signal over a fixed window of
// GATE_CYCLES system clocks and presents the held, saturating result.
module clk_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 25000000,
  parameter int CNT_BITS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sig_i,
  input  logic                start_i,
  input  logic                continuous_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [CNT_BITS-1:0] count_o,
  output logic                overflow_o
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  fm_state_e           state_q;
  logic [GW-1:0]       gate_cnt_q;
  logic [CNT_BITS-1:0] edge_cnt_q, edge_cnt_d;
  logic                ovf_q, ovf_d;
  logic [CNT_BITS-1:0] count_q;
  logic                overflow_q, valid_q, busy_q;
  logic                rise;
  logic                edge_all1;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(sig_i),
    .rise_o (rise)
  );

  // Saturating accumulation; a rise that finds the counter full marks overflow.
  always_comb begin
    edge_all1  = &edge_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (edge_all1) ovf_d = 1'b1;
      else           edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_GATE: begin
          gate_cnt_q <= gate_cnt_q + 1'b1;
          edge_cnt_q <= edge_cnt_d;
          ovf_q      <= ovf_d;
          // The final gate cycle's rise is folded into the published result.
          if (gate_cnt_q == GATE_LAST) begin
            state_q    <= ST_DONE;
            count_q    <= edge_cnt_d;
            overflow_q <= ovf_d;
            valid_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (continuous_i || start_i) begin
            state_q    <= ST_GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter with a 100-cycle gate; a 4-bit instance
// shares the stimulus to exercise counter saturation.
module tb_clk_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        busy, valid, ovf;
  logic [31:0] count;
  logic        busy4, valid4, ovf4;
  logic [3:0]  count4;

  int errors = 0;
  int checks = 0;
  int sig_mode = 2;
  int sig_per = 4;
  int ph = 0;

  clk_freq_meter #(.GATE_CYCLES(100), .CNT_BITS(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .start_i(start), .continuous_i(cont),
    .busy_o(busy), .valid_o(valid), .count_o(count), .overflow_o(ovf)
  );

  clk_freq_meter #(.GATE_CYCLES(100), .CNT_BITS(4), .SYNC_STAGES(2)) dut4 (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .start_i(start), .continuous_i(cont),
    .busy_o(busy4), .valid_o(valid4), .count_o(count4), .overflow_o(ovf4)
  );

  initial forever #5 clk = ~clk;

  // Signal generator: low, high, or square wave of sig_per clocks.
  initial forever begin
    @(negedge clk);
    if (sig_mode == 0) sig = 1'b0;
    else if (sig_mode == 1) sig = 1'b1;
    else begin
      sig = (ph < sig_per / 2);
      ph = (ph + 1) % sig_per;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // n = 1 for the current cycle; -1 when no valid pulse within limit cycles.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      if (valid === 1'b1) begin
        n = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL idle_count: got %0d want 0", count); end
  endtask

  task automatic test_single;
    int n;
    sig_mode = 2; sig_per = 10;
    repeat (30) @(posedge clk);
    do_start;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL single_latency: got cycle %0d want 101", n); end
    checks++; if (count !== 32'd10) begin errors++; $display("FAIL single_count: got %0d want 10", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", ovf); end
    checks++; if (count4 !== 4'd10) begin errors++; $display("FAIL single_count4: got %0d want 10", count4); end
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_to_idle: got %b want 0", busy); end
    checks++; if (count !== 32'd10) begin errors++; $display("FAIL single_hold: got %0d want 10", count); end
  endtask

  task automatic test_start_ignored;
    int n;
    do_start;
    repeat (49) begin @(posedge clk); #1; end
    start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_valid(200, n);
    checks++; if (n != 49) begin errors++; $display("FAIL ignore_latency: got %0d want 49", n); end
    checks++; if (count !== 32'd10) begin errors++; $display("FAIL ignore_count: got %0d want 10", count); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_to_idle: got %b want 0", busy); end
  endtask

  task automatic test_constant;
    int n;
    sig_mode = 0;
    repeat (10) @(posedge clk);
    do_start;
    repeat (49) begin @(posedge clk); #1; end
    checks++; if (count !== 32'd10) begin errors++; $display("FAIL const_hold: got %0d want 10", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL const_midgate_valid: got %b want 0", valid); end
    wait_valid(200, n);
    checks++; if (n != 52) begin errors++; $display("FAIL const0_latency: got %0d want 52", n); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL const0_count: got %0d want 0", count); end
    sig_mode = 1;
    repeat (10) @(posedge clk);
    do_start;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL const1_latency: got %0d want 101", n); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL const1_count: got %0d want 0", count); end
  endtask

  task automatic test_saturate;
    int n;
    sig_mode = 2; sig_per = 4;
    repeat (20) @(posedge clk);
    do_start;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL sat_latency: got %0d want 101", n); end
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL sat_valid4: got %b want 1", valid4); end
    checks++; if (count4 !== 4'd15) begin errors++; $display("FAIL sat_count4: got %0d want 15", count4); end
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL sat_ovf4: got %b want 1", ovf4); end
    checks++; if (count !== 32'd25) begin errors++; $display("FAIL sat_count32: got %0d want 25", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf32: got %b want 0", ovf); end
    sig_per = 10;
    repeat (20) @(posedge clk);
    do_start;
    wait_valid(200, n);
    checks++; if (count4 !== 4'd10) begin errors++; $display("FAIL unsat_count4: got %0d want 10", count4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL unsat_ovf4: got %b want 0", ovf4); end
  endtask

  task automatic test_continuous;
    int n;
    sig_per = 20;
    repeat (30) @(posedge clk);
    cont = 1'b1;
    do_start;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL cont_first_latency: got %0d want 101", n); end
    checks++; if (count !== 32'd5) begin errors++; $display("FAIL cont_first_count: got %0d want 5", count); end
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      wait_valid(200, n);
      checks++; if (n != 101) begin errors++; $display("FAIL cont_period%0d: got %0d want 101", r, n); end
      checks++; if (count !== 32'd5) begin errors++; $display("FAIL cont_count%0d: got %0d want 5", r, count); end
    end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %b want 1", busy); end
    cont = 1'b0;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL cont_last_period: got %0d want 101", n); end
    checks++; if (count !== 32'd5) begin errors++; $display("FAIL cont_last_count: got %0d want 5", count); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_to_idle: got %b want 0", busy); end
    wait_valid(150, n);
    checks++; if (n != -1) begin errors++; $display("FAIL cont_stopped: valid at %0d want none", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL b2b_first: got %0d want 101", n); end
    @(posedge clk);
    #1;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL b2b_period: got %0d want 101", n); end
    checks++; if (count !== 32'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", count); end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_to_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_gate;
    int n;
    do_start;
    repeat (49) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wait_valid(150, n);
    checks++; if (n != -1) begin errors++; $display("FAIL midrst_no_valid: valid at %0d want none", n); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL midrst_hold: got %0d want 0", count); end
    do_start;
    wait_valid(200, n);
    checks++; if (n != 101) begin errors++; $display("FAIL midrst_restart_latency: got %0d want 101", n); end
    checks++; if (count !== 32'd5) begin errors++; $display("FAIL midrst_restart_count: got %0d want 5", count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_start_ignored;
    test_constant;
    test_saturate;
    test_continuous;
    test_back_to_back;
    test_reset_mid_gate;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
